alu_operand_sequencer: RTL and testbench

Buffers a programmed list of ALU test operands and issues them one per handshake to the 16-bit ALU stage directly downstream. It drives `{op, a, b}`, reports the index of the vector it is presenting, and flags completion, so the ALU bench no longer reads vectors from a file. Vectors are loaded through a write port while the sequencer is idle, then issued in order after `start`.

---
 rtl/alu_operand_sequencer.sv | 146 ++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer.sv
// Stores ALU test vectors {op, a, b} and issues them in order, one per out_valid/out_ready handshake.
// Optional simulation trace of each transfer is compiled in when ALU_SEQ_TRACE_EN is defined.
module alu_operand_sequencer #(
  parameter int W     = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [2*W+2:0]   wr_data,
  input  logic             start,
  input  logic [AW:0]      count,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [W-1:0]     a,
  output logic [W-1:0]     b,
  output logic [2:0]       op,
  output logic [AW-1:0]    index,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

  state_t               state, state_d;
  logic [2*W+2:0]       mem [DEPTH];
  logic [2*W+2:0]       rd;
  logic [AW:0]          n_q, n_d, n_clamp;
  logic                 vld_p0, vld_d;
  logic [W-1:0]         a_p0, a_d, b_p0, b_d;
  logic [2:0]           op_p0, op_d;
  logic [AW-1:0]        idx_p0, idx_d, idx_nxt;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 xfer, last;

  // Vector storage: no reset, writes locked out while a sequence is running
  always_ff @(posedge clk) begin
    if (wr_en && (state != RUN)) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    n_clamp = (count > DEPTH_N) ? DEPTH_N : count;
    xfer    = vld_p0 && out_ready;
    last    = ({1'b0, idx_p0} == (n_q - 1'b1));
    idx_nxt = idx_p0 + 1'b1;
    // Storage is read before any same-edge write lands, so start sees old entry 0
    rd      = (state == RUN) ? mem[idx_nxt] : mem[0];

    state_d = state;
    n_d     = n_q;
    vld_d   = vld_p0;
    a_d     = a_p0;
    b_d     = b_p0;
    op_d    = op_p0;
    idx_d   = idx_p0;
    busy_d  = busy_q;
    done_d  = done_q;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          n_d = n_clamp;
          if (n_clamp != '0) begin
            {op_d, a_d, b_d} = rd;
            vld_d   = 1'b1;
            idx_d   = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            state_d = RUN;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (xfer) begin
          if (last) begin
            vld_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            {op_d, a_d, b_d} = rd;
            idx_d = idx_nxt;
          end
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // Output stage p0: every output comes straight from a flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      n_q    <= '0;
      vld_p0 <= 1'b0;
      a_p0   <= '0;
      b_p0   <= '0;
      op_p0  <= '0;
      idx_p0 <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      n_q    <= n_d;
      vld_p0 <= vld_d;
      a_p0   <= a_d;
      b_p0   <= b_d;
      op_p0  <= op_d;
      idx_p0 <= idx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign out_valid = vld_p0;
  assign a         = a_p0;
  assign b         = b_p0;
  assign op        = op_p0;
  assign index     = idx_p0;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef ALU_SEQ_TRACE_EN
  always @(posedge clk) begin
    if (!reset) begin
      if (xfer) $display("seq idx=%b op=%b a=%b b=%b", idx_p0, op_p0, a_p0, b_p0);
      if ((state_d == DONE) && (state != DONE)) $display("seq done");
    end
  end
`else
`endif

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench for alu_operand_sequencer: stimulus queues expected vectors, a monitor checks transfers.
module tb_alu_operand_sequencer;
  localparam int W = 16, DEPTH = 16, AW = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [2*W+2:0] wr_data;
  logic           start;
  logic [AW:0]    count;
  logic           out_ready;
  logic           out_valid;
  logic [W-1:0]   a, b;
  logic [2:0]     op;
  logic [AW-1:0]  index;
  logic           busy, done;

  alu_operand_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .count(count), .out_ready(out_ready), .out_valid(out_valid),
    .a(a), .b(b), .op(op), .index(index), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int xfers = 0;
  int base;
  logic [AW+2*W+2:0] exp_q[$];
  logic [2*W+2:0]    mdl [DEPTH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int addr, input logic [2:0] o, input logic [15:0] av, input logic [15:0] bv);
    wr_en = 1'b1; wr_addr = addr[AW-1:0]; wr_data = {o, av, bv};
    step();
    wr_en = 1'b0;
    mdl[addr] = {o, av, bv};
  endtask

  task automatic push(input int i, input logic [2:0] o, input logic [15:0] av, input logic [15:0] bv);
    exp_q.push_back({i[AW-1:0], o, av, bv});
  endtask

  task automatic push_mdl(input int i);
    exp_q.push_back({i[AW-1:0], mdl[i]});
  endtask

  task automatic go(input int n);
    start = 1'b1; count = n[AW:0];
    step();
    start = 1'b0;
  endtask

  // Monitor: every handshake seen before the edge must match the head of the queue
  always @(negedge clk) begin
    logic [AW+2*W+2:0] e;
    if (!reset && out_valid && out_ready) begin
      xfers++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_xfer actual=%0h required=none", {index, op, a, b});
      end else begin
        e = exp_q.pop_front();
        if ({index, op, a, b} !== e) begin
          fails++;
          $display("FAIL xfer actual=%0h required=%0h", {index, op, a, b}, e);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; count = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", {out_valid, busy, done, index, op, a, b}, '0);
    @(posedge clk); #1 reset = 1'b0;

    // Back-to-back issue of three hand-written vectors
    wr(0, 3'b000, 16'h0001, 16'h0002);
    wr(1, 3'b001, 16'hFFFF, 16'h0001);
    wr(2, 3'b010, 16'h00F0, 16'h0F00);
    push(0, 3'b000, 16'h0001, 16'h0002);
    push(1, 3'b001, 16'hFFFF, 16'h0001);
    push(2, 3'b010, 16'h00F0, 16'h0F00);
    out_ready = 1'b1;
    go(3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b2b_valid_busy", {out_valid, busy, index}, {1'b1, 1'b1, i[AW-1:0]});
      step();
    end
    @(negedge clk);
    chk("b2b_done", {done, busy, out_valid}, 3'b100);
    chk("b2b_drain", exp_q.size(), 0);

    // Backpressure: vector 0 held for five cycles
    @(posedge clk); #1;
    out_ready = 1'b0;
    push(0, 3'b000, 16'h0001, 16'h0002);
    push(1, 3'b001, 16'hFFFF, 16'h0001);
    go(2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {out_valid, index, op, a, b}, {1'b1, 4'd0, 3'b000, 16'h0001, 16'h0002});
      step();
    end
    base = xfers;
    out_ready = 1'b1;
    step(); step();
    @(negedge clk);
    chk("bp_done", done, 1'b1);
    chk("bp_xfers", xfers - base, 2);
    chk("bp_drain", exp_q.size(), 0);

    // Reset in the middle of a four-vector run
    @(posedge clk); #1;
    wr(3, 3'b011, 16'h1234, 16'h5678);
    for (int i = 0; i < 4; i++) push_mdl(i);
    out_ready = 1'b1;
    go(4);
    step(); step();
    out_ready = 1'b0;
    #2 reset = 1'b1;
    #1 chk("midrst_outs", {out_valid, busy, index}, '0);
    chk("midrst_pending", exp_q.size(), 2);
    while (exp_q.size() > 0) void'(exp_q.pop_front());
    @(posedge clk); #1 reset = 1'b0;

    // Zero count from IDLE
    go(0);
    @(negedge clk);
    chk("n0_done", {done, busy, out_valid}, 3'b100);
    step();

    // Rerun after reset reissues the stored data
    push(0, 3'b000, 16'h0001, 16'h0002);
    push(1, 3'b001, 16'hFFFF, 16'h0001);
    push(2, 3'b010, 16'h00F0, 16'h0F00);
    push(3, 3'b011, 16'h1234, 16'h5678);
    out_ready = 1'b1;
    go(4);
    repeat (4) step();
    @(negedge clk);
    chk("rerun_done", {done, out_valid}, 2'b10);
    chk("rerun_drain", exp_q.size(), 0);

    // Count above DEPTH is clamped
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++) wr(i, i[2:0], 16'hA000 + 16'(i), 16'h00FF ^ 16'(i));
    for (int i = 0; i < DEPTH; i++) push_mdl(i);
    base = xfers;
    go(20);
    repeat (DEPTH) step();
    @(negedge clk);
    chk("clamp_done", {done, out_valid}, 2'b10);
    chk("clamp_xfers", xfers - base, DEPTH);
    chk("clamp_drain", exp_q.size(), 0);

    // start and wr_en mid-run are ignored
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) push_mdl(i);
    go(4);
    step();
    start = 1'b1; count = 5'd1;
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = {3'b111, 16'hDEAD, 16'hBEEF};
    step();
    start = 1'b0; wr_en = 1'b0;
    step(); step();
    @(negedge clk);
    chk("ign_done", done, 1'b1);
    chk("ign_drain", exp_q.size(), 0);
    @(posedge clk); #1;
    push_mdl(0); push_mdl(1);
    go(2);
    step(); step();
    @(negedge clk);
    chk("ign_entry1_drain", exp_q.size(), 0);

    // Restart from DONE with N=1, with a same-edge write to entry 0
    @(posedge clk); #1;
    chk("restart_pre_done", done, 1'b1);
    out_ready = 1'b0;
    push_mdl(0);
    start = 1'b1; count = 5'd1;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = {3'b101, 16'h5555, 16'hAAAA};
    step();
    start = 1'b0; wr_en = 1'b0;
    mdl[0] = {3'b101, 16'h5555, 16'hAAAA};
    @(negedge clk);
    chk("restart_edge", {done, out_valid, busy}, 3'b011);
    step();
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("restart_done", {done, out_valid}, 2'b10);
    chk("restart_drain", exp_q.size(), 0);
    @(posedge clk); #1;
    push_mdl(0);
    go(1);
    step();
    @(negedge clk);
    chk("newentry0_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
